// File: rtl/iram_pkg.sv
// Shared widths, port ids and the read-return tag for the work-RAM arbiter.
package iram_pkg;
   localparam int IRAM_AW = 13;
   localparam int IRAM_DW = 8;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   typedef struct packed {
      logic vld;
      logic port;
   } rd_tag_t;
endpackage

// File: rtl/iram_arbiter.sv
// CPU/DMA arbiter for the single-ported work RAM; DMA priority with CPU aging override.
// Grant 0 cycles, read return 1 cycle; a refused requester holds its request until granted.
module iram_arbiter
   import iram_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cpu_req,
   input  logic               cpu_we,
   input  logic [IRAM_AW-1:0] cpu_addr,
   input  logic [IRAM_DW-1:0] cpu_wdata,
   output logic               cpu_gnt,
   output logic               cpu_rvalid,
   output logic [IRAM_DW-1:0] cpu_rdata,
   input  logic               dma_req,
   input  logic               dma_we,
   input  logic [IRAM_AW-1:0] dma_addr,
   input  logic [IRAM_DW-1:0] dma_wdata,
   output logic               dma_gnt,
   output logic               dma_rvalid,
   output logic [IRAM_DW-1:0] dma_rdata,
   output logic [IRAM_AW-1:0] ram_address,
   output logic [IRAM_DW-1:0] ram_data,
   output logic               ram_wren,
   input  logic [IRAM_DW-1:0] ram_q
);

   localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

   logic [3:0]         cpu_wait;
   logic               starved;
   rd_tag_t            rd_tag;
   logic [IRAM_DW-1:0] cpu_rdata_q;
   logic [IRAM_DW-1:0] dma_rdata_q;

   assign starved = (cpu_wait == WAIT_LIMIT);

   always_comb begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
      if (!reset) begin
         if (starved && cpu_req) begin
            cpu_gnt = 1'b1;
         end else if (dma_req) begin
            dma_gnt = 1'b1;
         end else if (cpu_req) begin
            cpu_gnt = 1'b1;
         end
      end
   end

   // With no winner the CPU fields are presented but never written.
   always_comb begin
      ram_address = cpu_addr;
      ram_data    = cpu_wdata;
      ram_wren    = cpu_gnt & cpu_we;
      if (dma_gnt) begin
         ram_address = dma_addr;
         ram_data    = dma_wdata;
         ram_wren    = dma_we;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cpu_wait <= 4'd0;
      end else if (!cpu_req || cpu_gnt) begin
         cpu_wait <= 4'd0;
      end else if (!starved) begin
         cpu_wait <= cpu_wait + 4'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_tag <= '0;
      end else begin
         rd_tag.vld  <= (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
         rd_tag.port <= dma_gnt ? PORT_DMA : PORT_CPU;
      end
   end

   // Gated by reset so a read granted just before reset never returns.
   assign cpu_rvalid = rd_tag.vld && (rd_tag.port == PORT_CPU) && !reset;
   assign dma_rvalid = rd_tag.vld && (rd_tag.port == PORT_DMA) && !reset;

   always_ff @(posedge clock) begin
      if (reset) begin
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         if (cpu_rvalid) cpu_rdata_q <= ram_q;
         if (dma_rvalid) dma_rdata_q <= ram_q;
      end
   end

   // ram_q is live during the return cycle; the registers hold it afterwards.
   assign cpu_rdata = cpu_rvalid ? ram_q : cpu_rdata_q;
   assign dma_rdata = dma_rvalid ? ram_q : dma_rdata_q;

endmodule

// File: tb/tb_iram_arbiter.sv
// Bench for iram_arbiter: RAM model, per-cycle reference model and directed vectors.
module tb_iram_arbiter;
   import iram_pkg::*;

   localparam int MW = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [12:0] cpu_addr, dma_addr;
   logic [7:0]  cpu_wdata, dma_wdata;
   logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
   logic [7:0]  cpu_rdata, dma_rdata;
   logic [12:0] ram_address;
   logic [7:0]  ram_data;
   logic        ram_wren;
   logic [7:0]  ram_q;

   logic [7:0]  mem [0:8191];

   int tests = 0;
   int fails = 0;

   iram_arbiter #(.MAX_WAIT(MW)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
   );

   always #5 clock = ~clock;

   // Single-ported RAM with registered read.
   always @(posedge clock) begin
      if (ram_wren) mem[ram_address] <= ram_data;
      ram_q <= mem[ram_address];
   end

   function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: refused-cycle count, shadow memory, queue of owed read returns.
   typedef struct {
      logic       port;
      logic [7:0] data;
   } ret_t;

   ret_t       ret_q[$];
   int         m_wait = 0;
   logic [7:0] smem [0:8191];
   logic [7:0] hold_c = 8'h00;
   logic [7:0] hold_d = 8'h00;

   initial begin : model
      logic       ec, ed, rc, rd, have;
      logic [7:0] dc, dd;
      ret_t       r;
      @(posedge clock);
      forever begin
         @(negedge clock);
         ec = 1'b0; ed = 1'b0; rc = 1'b0; rd = 1'b0; have = 1'b0;
         r = '{PORT_CPU, 8'h00};
         if (ret_q.size() > 0) begin
            r = ret_q.pop_front();
            have = 1'b1;
         end
         if (!reset) begin
            if (cpu_req && m_wait >= MW) ec = 1'b1;
            else if (dma_req)            ed = 1'b1;
            else if (cpu_req)            ec = 1'b1;
            if (have) begin
               rc = (r.port == PORT_CPU);
               rd = (r.port == PORT_DMA);
            end
         end
         dc = rc ? r.data : hold_c;
         dd = rd ? r.data : hold_d;

         check("m_cpu_gnt",    16'(cpu_gnt),    16'(ec));
         check("m_dma_gnt",    16'(dma_gnt),    16'(ed));
         check("m_cpu_rvalid", 16'(cpu_rvalid), 16'(rc));
         check("m_dma_rvalid", 16'(dma_rvalid), 16'(rd));
         check("m_cpu_rdata",  16'(cpu_rdata),  16'(dc));
         check("m_dma_rdata",  16'(dma_rdata),  16'(dd));
         check("m_ram_wren",   16'(ram_wren),   16'(ed ? dma_we : (ec & cpu_we)));
         check("m_ram_addr",   16'(ram_address), 16'(ed ? dma_addr : cpu_addr));
         check("m_ram_data",   16'(ram_data),   16'(ed ? dma_wdata : cpu_wdata));

         if (reset) begin
            m_wait = 0;
            hold_c = 8'h00;
            hold_d = 8'h00;
            ret_q.delete();
         end else begin
            hold_c = dc;
            hold_d = dd;
            if (ed && dma_we) smem[dma_addr] = dma_wdata;
            if (ec && cpu_we) smem[cpu_addr] = cpu_wdata;
            if (ed && !dma_we) ret_q.push_back('{PORT_DMA, smem[dma_addr]});
            if (ec && !cpu_we) ret_q.push_back('{PORT_CPU, smem[cpu_addr]});
            if (cpu_req && !ec) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
            else                m_wait = 0;
         end
      end
   end

   task automatic drive(input logic cr, input logic cw, input logic [12:0] ca, input logic [7:0] cd,
                        input logic dr, input logic dw, input logic [12:0] da, input logic [7:0] dwd);
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dwd;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 13'h0000, 8'h00, 1'b0, 1'b0, 13'h0000, 8'h00);
   endtask

   task automatic next();
      @(posedge clock);
      #1;
   endtask

   task automatic mid();
      @(negedge clock);
   endtask

   initial begin : stim
      reset = 1'b1;
      drive(1'b1, 1'b1, 13'h0001, 8'hEE, 1'b1, 1'b1, 13'h0002, 8'hDD);
      next();
      mid();
      check("rst_cpu_gnt", 16'(cpu_gnt), 16'h0);
      check("rst_dma_gnt", 16'(dma_gnt), 16'h0);
      check("rst_wren",    16'(ram_wren), 16'h0);
      next();
      reset = 1'b0;
      idle();
      mid();
      check("rel_cpu_rvalid", 16'(cpu_rvalid), 16'h0);
      check("rel_dma_rvalid", 16'(dma_rvalid), 16'h0);
      check("rel_cpu_rdata",  16'(cpu_rdata),  16'h00);
      check("rel_dma_rdata",  16'(dma_rdata),  16'h00);
      next();

      // Preload through the ports.
      drive(1'b0, 1'b0, 13'h0000, 8'h00, 1'b1, 1'b1, 13'h1FFF, 8'hC3);
      next();
      drive(1'b1, 1'b1, 13'h0200, 8'h77, 1'b0, 1'b0, 13'h0000, 8'h00);
      next();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b1, 13'h0400 + 13'(i), 8'hA0 + 8'(i), 1'b0, 1'b0, 13'h0000, 8'h00);
         next();
      end

      // Single port write then read.
      drive(1'b1, 1'b1, 13'h0123, 8'h5A, 1'b0, 1'b0, 13'h0000, 8'h00);
      mid();
      check("sp_wr_gnt",  16'(cpu_gnt), 16'h1);
      check("sp_wr_wren", 16'(ram_wren), 16'h1);
      next();
      drive(1'b1, 1'b0, 13'h0123, 8'h00, 1'b0, 1'b0, 13'h0000, 8'h00);
      mid();
      check("sp_rd_gnt", 16'(cpu_gnt), 16'h1);
      next();
      idle();
      mid();
      check("sp_rvalid", 16'(cpu_rvalid), 16'h1);
      check("sp_rdata",  16'(cpu_rdata),  16'h5A);
      next();

      // Simultaneous requests: DMA wins.
      drive(1'b1, 1'b0, 13'h0010, 8'h00, 1'b1, 1'b0, 13'h1FFF, 8'h00);
      mid();
      check("pri_dma_gnt", 16'(dma_gnt), 16'h1);
      check("pri_cpu_gnt", 16'(cpu_gnt), 16'h0);
      next();
      idle();
      mid();
      check("pri_dma_rvalid", 16'(dma_rvalid), 16'h1);
      check("pri_dma_rdata",  16'(dma_rdata),  16'hC3);
      check("pri_cpu_rvalid", 16'(cpu_rvalid), 16'h0);
      next();

      // Starvation under continuous DMA.
      for (int k = 0; k < 6; k++) begin
         drive(k <= 4, 1'b0, 13'h0200, 8'h00, 1'b1, 1'b0, 13'h0400 + 13'(k), 8'h00);
         mid();
         check("stv_cpu_gnt", 16'(cpu_gnt), (k == 4) ? 16'h1 : 16'h0);
         check("stv_dma_gnt", 16'(dma_gnt), (k == 4) ? 16'h0 : 16'h1);
         if (k == 5) begin
            check("stv_cpu_rvalid", 16'(cpu_rvalid), 16'h1);
            check("stv_cpu_rdata",  16'(cpu_rdata),  16'h77);
         end
         next();
      end
      idle();
      next();

      // Alternating reads, one port per cycle.
      for (int i = 0; i < 7; i++) begin
         if (i < 6) begin
            if (i % 2 == 0) drive(1'b1, 1'b0, 13'h0400 + 13'(i), 8'h00, 1'b0, 1'b0, 13'h0000, 8'h00);
            else            drive(1'b0, 1'b0, 13'h0000, 8'h00, 1'b1, 1'b0, 13'h0400 + 13'(i), 8'h00);
         end else begin
            idle();
         end
         mid();
         if (i > 0) begin
            if ((i - 1) % 2 == 0) begin
               check("il_cpu_rvalid", 16'(cpu_rvalid), 16'h1);
               check("il_dma_rvalid", 16'(dma_rvalid), 16'h0);
               check("il_cpu_rdata",  16'(cpu_rdata),  16'(8'hA0 + 8'(i - 1)));
            end else begin
               check("il_dma_rvalid", 16'(dma_rvalid), 16'h1);
               check("il_cpu_rvalid", 16'(cpu_rvalid), 16'h0);
               check("il_dma_rdata",  16'(dma_rdata),  16'(8'hA0 + 8'(i - 1)));
            end
         end
         next();
      end

      // Reset with a DMA read in flight.
      drive(1'b0, 1'b0, 13'h0000, 8'h00, 1'b1, 1'b0, 13'h1FFF, 8'h00);
      mid();
      check("rmr_dma_gnt", 16'(dma_gnt), 16'h1);
      next();
      reset = 1'b1;
      mid();
      check("rmr_rst_rvalid", 16'(dma_rvalid), 16'h0);
      check("rmr_rst_gnt",    16'(dma_gnt),    16'h0);
      next();
      reset = 1'b0;
      idle();
      mid();
      check("rmr_post_rvalid", 16'(dma_rvalid), 16'h0);
      check("rmr_post_rdata",  16'(dma_rdata),  16'h00);
      next();
      mid();
      check("rmr_late_rvalid", 16'(dma_rvalid), 16'h0);
      next();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
